// File: rtl/a2d_pkg.sv
// Shared types and helpers for the ADC128S-class scanning A2D interface.
package a2d_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FRM1,
      GAP,
      FRM2,
      DONE
   } a2d_state_t;

   // Bit position of the 3-bit channel address inside a 16-bit command word.
   localparam int FRAME_CMD_SHIFT = 11;

   // Command word {2'b00, ch[2:0], 11'b0}; wider frames left-align it in the top.
   function automatic logic [15:0] build_tx_word(input logic [2:0] ch);
      return 16'(ch) << FRAME_CMD_SHIFT;
   endfunction

endpackage

// File: rtl/a2d_spi_frame.sv
// One SPI frame engine: SS_n window, SCLK divider, bit counter, tx/rx shifters.
// A frame lasts (FRAME_W+1)*DIV clks from the start edge: FRAME_W SCLK periods
// (high half first) followed by one DIV-long back porch with SCLK high.
module a2d_spi_frame #(
   parameter int FRAME_W = 16,
   parameter int RX_W    = 12,
   parameter int DIV     = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [FRAME_W-1:0] tx,
   output logic               done,
   output logic [RX_W-1:0]    rx,
   output logic               ss_n,
   output logic               sclk,
   output logic               mosi,
   input  logic               miso
);

   localparam int DIV_W = $clog2(DIV);
   localparam int BIT_W = $clog2(FRAME_W + 1);

   logic               active;
   logic [DIV_W-1:0]   div_cnt;
   logic [BIT_W-1:0]   bit_cnt;
   logic [FRAME_W-1:0] tx_sr;
   logic               in_bits;
   logic               fall_pt;
   logic               rise_pt;
   logic               div_last;

   assign div_last = (div_cnt == DIV_W'(DIV - 1));
   assign in_bits  = (bit_cnt != BIT_W'(FRAME_W));
   assign fall_pt  = active && in_bits && (div_cnt == DIV_W'(DIV / 2 - 1));
   assign rise_pt  = active && in_bits && div_last;
   // Strobe in the last clk of the back porch; SS_n rises on the following edge.
   assign done     = active && !in_bits && div_last;

   // Frame sequencer: counters, SCLK edges, MOSI launch on fall, MISO capture on rise.
   always_ff @(posedge clk) begin
      // NOTE: every sequential assignment is non-blocking so all registers see
      // pre-edge values; blocking here would create order-dependent simulation.
      if (rst) begin
         active  <= 1'b0;
         ss_n    <= 1'b1;
         sclk    <= 1'b1;
         mosi    <= 1'b0;
         div_cnt <= '0;
         bit_cnt <= '0;
         tx_sr   <= '0;
         rx      <= '0;
      end else if (start) begin
         active  <= 1'b1;
         ss_n    <= 1'b0;
         sclk    <= 1'b1;
         div_cnt <= '0;
         bit_cnt <= '0;
         tx_sr   <= tx;
      end else if (active) begin
         if (div_last) begin
            div_cnt <= '0;
            bit_cnt <= bit_cnt + BIT_W'(1);
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
         if (fall_pt) begin
            sclk  <= 1'b0;
            mosi  <= tx_sr[FRAME_W-1];
            tx_sr <= {tx_sr[FRAME_W-2:0], 1'b0};
         end
         // Shifting RX_W bits keeps only the trailing RX_W bits of the frame.
         if (rise_pt) begin
            sclk <= 1'b1;
            rx   <= {rx[RX_W-2:0], miso};
         end
         if (done) begin
            active <= 1'b0;
            ss_n   <= 1'b1;
            mosi   <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/a2d_scan_intf.sv
// SPI master for ADC128S-class converters: single conversions plus an autonomous
// round-robin scan into a result bank. Each conversion is two frames (address,
// then data) separated by GAP_CYC clks of SS_n high.
// Optional build macro A2D_FRESH_EN adds per-channel fresh flags (fresh/rd_ack).
module a2d_scan_intf
   import a2d_pkg::*;
#(
   parameter  int NUM_CHNL = 8,
   parameter  int RES_W    = 12,
   parameter  int FRAME_W  = 16,
   parameter  int DIV      = 32,
   parameter  int GAP_CYC  = 2,
   localparam int ADDR_W   = $clog2(NUM_CHNL)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                strt_cnv,
   input  logic [ADDR_W-1:0]   chnnl,
   input  logic                scan_en,
   input  logic [ADDR_W-1:0]   rd_chnnl,
   output logic [RES_W-1:0]    rd_res,
   output logic [RES_W-1:0]    res,
   output logic [ADDR_W-1:0]   res_chnnl,
   output logic                cnv_cmplt,
   output logic                scan_wrap,
   output logic                busy,
`ifdef A2D_FRESH_EN
   input  logic                rd_ack,
   output logic [NUM_CHNL-1:0] fresh,
`endif
   output logic                a2d_SS_n,
   output logic                SCLK,
   output logic                MOSI,
   input  logic                MISO
);

   localparam int GAP_W = $clog2(GAP_CYC + 1);

   a2d_state_t         state;
   logic [ADDR_W-1:0]  cur_ch;
   logic [ADDR_W-1:0]  ptr;
   logic [ADDR_W-1:0]  ptr_next;
   logic [ADDR_W-1:0]  start_ch;
   logic [2:0]         start_ch3;
   logic               scan_mode;
   logic [GAP_W-1:0]   gap_cnt;
   logic               accept;
   logic               gap_last;
   logic               rescan;
   logic               frm_start;
   logic               frm_done;
   logic [FRAME_W-1:0] frm_tx;
   logic [RES_W-1:0]   frm_rx;
   logic               ch_valid;
   logic               bank_wr;
   logic [RES_W-1:0]   bank [0:NUM_CHNL-1];

   // busy is only high in IDLE during the cnv_cmplt cycle, so that cycle rejects starts too.
   assign accept    = (state == IDLE) && !busy && (scan_en || strt_cnv);
   assign gap_last  = (state == GAP) && (gap_cnt == GAP_W'(GAP_CYC - 1));
   assign rescan    = (state == DONE) && scan_en;
   assign frm_start = accept || gap_last || rescan;
   assign ptr_next  = (ptr == ADDR_W'(NUM_CHNL - 1)) ? '0 : ptr + ADDR_W'(1);
   assign ch_valid  = ({1'b0, cur_ch} < (ADDR_W + 1)'(NUM_CHNL));
   assign bank_wr   = (state == DONE) && ch_valid;
   assign rd_res    = bank[rd_chnnl];

   // Channel addressed by a frame launched this cycle (the frame latches its tx word on start).
   always_comb begin
      // NOTE: default first so every path assigns start_ch and no latch is inferred.
      start_ch = cur_ch;
      case (state)
         IDLE:    start_ch = scan_en ? ptr : chnnl;
         DONE:    start_ch = scan_mode ? ptr_next : ptr;
         default: start_ch = cur_ch;
      endcase
   end

   assign start_ch3 = 3'(start_ch);
   assign frm_tx    = FRAME_W'(build_tx_word(start_ch3)) << (FRAME_W - 16);

   a2d_spi_frame #(
      .FRAME_W (FRAME_W),
      .RX_W    (RES_W),
      .DIV     (DIV)
   ) u_frame (
      .clk   (clk),
      .rst   (rst),
      .start (frm_start),
      .tx    (frm_tx),
      .done  (frm_done),
      .rx    (frm_rx),
      .ss_n  (a2d_SS_n),
      .sclk  (SCLK),
      .mosi  (MOSI),
      .miso  (MISO)
   );

   // Conversion FSM with registered status outputs and scan pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cur_ch    <= '0;
         scan_mode <= 1'b0;
         ptr       <= '0;
         gap_cnt   <= '0;
         busy      <= 1'b0;
         cnv_cmplt <= 1'b0;
         scan_wrap <= 1'b0;
         res       <= '0;
         res_chnnl <= '0;
      end else begin
         cnv_cmplt <= 1'b0;
         scan_wrap <= 1'b0;
         unique case (state)
            IDLE: begin
               busy <= accept;
               if (accept) begin
                  state     <= FRM1;
                  cur_ch    <= start_ch;
                  scan_mode <= scan_en;
               end
            end
            FRM1: begin
               if (frm_done) begin
                  state   <= GAP;
                  gap_cnt <= '0;
               end
            end
            GAP: begin
               if (gap_last) state <= FRM2;
               else          gap_cnt <= gap_cnt + GAP_W'(1);
            end
            FRM2: begin
               if (frm_done) state <= DONE;
            end
            DONE: begin
               res       <= frm_rx;
               res_chnnl <= cur_ch;
               cnv_cmplt <= 1'b1;
               scan_wrap <= scan_mode && (cur_ch == ADDR_W'(NUM_CHNL - 1));
               if (scan_mode) ptr <= ptr_next;
               if (scan_en) begin
                  state     <= FRM1;
                  cur_ch    <= start_ch;
                  scan_mode <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Result bank; out-of-range channels (non-power-of-two NUM_CHNL) are not stored.
   always_ff @(posedge clk) begin
      // NOTE: the bank is cleared on reset because its contents are readable outputs;
      // this forces flops rather than a RAM macro, acceptable at NUM_CHNL <= 8.
      if (rst) begin
         for (int i = 0; i < NUM_CHNL; i++) bank[i] <= '0;
      end else if (bank_wr) begin
         bank[cur_ch] <= frm_rx;
      end
   end

`ifdef A2D_FRESH_EN
   // Fresh flags: set on bank write, cleared by an acknowledged read; set wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         fresh <= '0;
      end else begin
         for (int i = 0; i < NUM_CHNL; i++) begin
            if (bank_wr && (cur_ch == ADDR_W'(i)))        fresh[i] <= 1'b1;
            else if (rd_ack && (rd_chnnl == ADDR_W'(i)))  fresh[i] <= 1'b0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_a2d_scan_intf.sv
// Directed bench for a2d_scan_intf with a behavioural ADC128S model.
// Fresh-flag scenarios run only when A2D_FRESH_EN is defined.
module tb_a2d_scan_intf;

   localparam int NUM_CHNL  = 8;
   localparam int RES_W     = 12;
   localparam int FRAME_W   = 16;
   localparam int DIV       = 32;
   localparam int GAP_CYC   = 2;
   localparam int FRAME_CYC = (FRAME_W + 1) * DIV;
   localparam int LAT       = 2 * FRAME_CYC + GAP_CYC + 1;

   logic             clk;
   logic             rst;
   logic             strt_cnv;
   logic [2:0]       chnnl;
   logic             scan_en;
   logic [2:0]       rd_chnnl;
   logic [RES_W-1:0] rd_res;
   logic [RES_W-1:0] res;
   logic [2:0]       res_chnnl;
   logic             cnv_cmplt;
   logic             scan_wrap;
   logic             busy;
   logic             a2d_SS_n;
   logic             SCLK;
   logic             MOSI;
   logic             MISO;
`ifdef A2D_FRESH_EN
   logic             rd_ack;
   logic [7:0]       fresh;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   a2d_scan_intf #(
      .NUM_CHNL (NUM_CHNL),
      .RES_W    (RES_W),
      .FRAME_W  (FRAME_W),
      .DIV      (DIV),
      .GAP_CYC  (GAP_CYC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .strt_cnv  (strt_cnv),
      .chnnl     (chnnl),
      .scan_en   (scan_en),
      .rd_chnnl  (rd_chnnl),
      .rd_res    (rd_res),
      .res       (res),
      .res_chnnl (res_chnnl),
      .cnv_cmplt (cnv_cmplt),
      .scan_wrap (scan_wrap),
      .busy      (busy),
`ifdef A2D_FRESH_EN
      .rd_ack    (rd_ack),
      .fresh     (fresh),
`endif
      .a2d_SS_n  (a2d_SS_n),
      .SCLK      (SCLK),
      .MOSI      (MOSI),
      .MISO      (MISO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ADC model: address shifted in on SCLK rise, latched at SS_n rise;
   // the next frame returns {4'b0, data[addr]} MSB first, shifting after each rise.
   logic [11:0] adc_mem [0:7];
   logic [15:0] din       = '0;
   logic [15:0] dout      = '0;
   logic [2:0]  addr      = '0;
   logic [15:0] last_word = '0;
   int          nrise     = 0;

   always @(negedge a2d_SS_n) begin
      dout  <= {4'b0, adc_mem[addr]};
      din   <= '0;
      nrise <= 0;
   end
   always @(posedge a2d_SS_n) begin
      addr      <= din[13:11];
      last_word <= din;
   end
   always @(posedge SCLK) if (a2d_SS_n === 1'b0) begin
      din   <= {din[14:0], MOSI};
      nrise <= nrise + 1;
   end
   always @(negedge SCLK) if (a2d_SS_n === 1'b0 && nrise > 0) dout <= {dout[14:0], 1'b0};
   assign MISO = a2d_SS_n ? 1'b0 : dout[15];

   // Global time limit.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
      $fatal(1, "timeout");
   end

   task automatic wait_cmplt(input int budget, output int cyc, output bit seen);
      seen = 1'b0;
      cyc  = 0;
      while (cyc < budget && !seen) begin
         @(posedge clk); #1;
         cyc++;
         if (cnv_cmplt) seen = 1'b1;
      end
   endtask

   task automatic pulse_start(input logic [2:0] ch);
      @(negedge clk);
      chnnl    = ch;
      strt_cnv = 1'b1;
      @(posedge clk); #1;
      strt_cnv = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({a2d_SS_n, SCLK, MOSI, busy, cnv_cmplt, scan_wrap} !== 6'b110000) begin
         n_bad++;
         $display("FAIL reset_ctl: got %b want 110000", {a2d_SS_n, SCLK, MOSI, busy, cnv_cmplt, scan_wrap});
      end
      n_cmp++;
      if (res !== 12'h000 || res_chnnl !== 3'd0) begin
         n_bad++;
         $display("FAIL reset_res: got res=%h ch=%0d want 000/0", res, res_chnnl);
      end
      rd_chnnl = 3'd7; #1;
      n_cmp++;
      if (rd_res !== 12'h000) begin
         n_bad++;
         $display("FAIL reset_bank7: got %h want 000", rd_res);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_single;
      int  cyc = 0, t_done = -1, n_pulse = 0;
      logic busy_at = 1'b0, busy_after = 1'b1;
      logic [11:0] res_at = '0;
      logic [2:0]  ch_at = '0;
      pulse_start(3'd3);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL single_busy_accept: got %b want 1", busy);
      end
      while (cyc < LAT + 200) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 100) strt_cnv = 1'b1;
         if (cyc == 101) strt_cnv = 1'b0;
         if (cnv_cmplt) begin
            n_pulse++;
            if (t_done < 0) begin
               t_done  = cyc;
               busy_at = busy;
               res_at  = res;
               ch_at   = res_chnnl;
            end
         end
         if (t_done > 0 && cyc == t_done + 1) busy_after = busy;
      end
      n_cmp++;
      if (t_done !== LAT) begin
         n_bad++;
         $display("FAIL single_latency: got %0d want %0d", t_done, LAT);
      end
      n_cmp++;
      if (res_at !== 12'hA5C || ch_at !== 3'd3) begin
         n_bad++;
         $display("FAIL single_res: got %h ch %0d want a5c ch 3", res_at, ch_at);
      end
      n_cmp++;
      if (n_pulse !== 1) begin
         n_bad++;
         $display("FAIL single_pulse_count: got %0d want 1", n_pulse);
      end
      n_cmp++;
      if (busy_at !== 1'b1 || busy_after !== 1'b0) begin
         n_bad++;
         $display("FAIL single_busy_window: got %b%b want 10", busy_at, busy_after);
      end
      n_cmp++;
      if (last_word !== 16'h1800) begin
         n_bad++;
         $display("FAIL single_mosi_word: got %h want 1800", last_word);
      end
      rd_chnnl = 3'd3; #1;
      n_cmp++;
      if (rd_res !== 12'hA5C) begin
         n_bad++;
         $display("FAIL single_bank3: got %h want a5c", rd_res);
      end
   endtask

   task automatic test_reset_mid_frame;
      int cyc; bit seen;
      pulse_start(3'd6);
      repeat (300) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if ({a2d_SS_n, SCLK, busy} !== 3'b110 || res !== 12'h000) begin
         n_bad++;
         $display("FAIL midrst_state: got ss/sclk/busy=%b res=%h want 110 000", {a2d_SS_n, SCLK, busy}, res);
      end
      repeat (2) @(posedge clk);
      #1;
      rd_chnnl = 3'd3; #1;
      n_cmp++;
      if (rd_res !== 12'h000) begin
         n_bad++;
         $display("FAIL midrst_bank3: got %h want 000", rd_res);
      end
      @(negedge clk);
      rst = 1'b0;
      pulse_start(3'd6);
      wait_cmplt(LAT + 10, cyc, seen);
      n_cmp++;
      if (!seen || cyc !== LAT || res !== 12'h601 || res_chnnl !== 3'd6) begin
         n_bad++;
         $display("FAIL midrst_reconvert: seen=%b cyc=%0d res=%h ch=%0d want 1 %0d 601 6", seen, cyc, res, res_chnnl, LAT);
      end
   endtask

   task automatic test_scan;
      int cyc; bit seen;
      logic [2:0]  exp_ch;
      logic [11:0] exp_res;
      int n_wrap = 0;
      adc_mem[3] = 12'h301;
      repeat (20) @(posedge clk);
      @(negedge clk);
      scan_en = 1'b1;
      for (int k = 0; k < 9; k++) begin
         exp_ch  = 3'(k % 8);
         exp_res = 12'h100 * 12'(exp_ch) + 12'h001;
         wait_cmplt(LAT + 10, cyc, seen);
         if (scan_wrap) n_wrap++;
         n_cmp++;
         if (!seen || res_chnnl !== exp_ch || res !== exp_res) begin
            n_bad++;
            $display("FAIL scan_conv%0d: seen=%b ch=%0d res=%h want ch %0d res %h", k, seen, res_chnnl, res, exp_ch, exp_res);
         end
         n_cmp++;
         if (scan_wrap !== (exp_ch == 3'd7)) begin
            n_bad++;
            $display("FAIL scan_wrap%0d: got %b want %b", k, scan_wrap, exp_ch == 3'd7);
         end
      end
      n_cmp++;
      if (n_wrap !== 1) begin
         n_bad++;
         $display("FAIL scan_wrap_count: got %0d want 1", n_wrap);
      end
      for (int c = 0; c < 8; c++) begin
         rd_chnnl = 3'(c); #1;
         n_cmp++;
         if (rd_res !== 12'h100 * 12'(c) + 12'h001) begin
            n_bad++;
            $display("FAIL scan_bank%0d: got %h want %h", c, rd_res, 12'h100 * 12'(c) + 12'h001);
         end
      end
`ifdef A2D_FRESH_EN
      n_cmp++;
      if (fresh !== 8'hFF) begin
         n_bad++;
         $display("FAIL fresh_after_pass: got %h want ff", fresh);
      end
      rd_chnnl = 3'd5;
      rd_ack   = 1'b1;
      @(posedge clk); #1;
      rd_ack = 1'b0;
      n_cmp++;
      if (fresh !== 8'hDF) begin
         n_bad++;
         $display("FAIL fresh_ack5: got %h want df", fresh);
      end
`endif
   endtask

   task automatic test_scan_stop;
      int cyc; bit seen;
      wait_cmplt(LAT + 10, cyc, seen);
      n_cmp++;
      if (!seen || res_chnnl !== 3'd1 || res !== 12'h101) begin
         n_bad++;
         $display("FAIL stop_ch1: seen=%b ch=%0d res=%h want 1 101", seen, res_chnnl, res);
      end
      repeat (FRAME_CYC + GAP_CYC + 100) @(posedge clk);
      #1;
      scan_en = 1'b0;
      wait_cmplt(LAT + 10, cyc, seen);
      n_cmp++;
      if (!seen || res_chnnl !== 3'd2 || res !== 12'h201) begin
         n_bad++;
         $display("FAIL stop_ch2: seen=%b ch=%0d res=%h want 2 201", seen, res_chnnl, res);
      end
      repeat (50) @(posedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b0 || a2d_SS_n !== 1'b1) begin
         n_bad++;
         $display("FAIL stop_idle: busy=%b ss_n=%b want 0 1", busy, a2d_SS_n);
      end
      rd_chnnl = 3'd2; #1;
      n_cmp++;
      if (rd_res !== 12'h201) begin
         n_bad++;
         $display("FAIL stop_bank2: got %h want 201", rd_res);
      end
      // Re-enable with a competing single-start request: scan must win, resuming at ch3.
      @(negedge clk);
      scan_en  = 1'b1;
      strt_cnv = 1'b1;
      chnnl    = 3'd6;
      @(posedge clk); #1;
      scan_en  = 1'b0;
      strt_cnv = 1'b0;
      wait_cmplt(LAT + 10, cyc, seen);
      n_cmp++;
      if (!seen || cyc !== LAT || res_chnnl !== 3'd3 || res !== 12'h301) begin
         n_bad++;
         $display("FAIL resume_ch3: seen=%b cyc=%0d ch=%0d res=%h want 1 %0d 3 301", seen, cyc, res_chnnl, res, LAT);
      end
      repeat (20) @(posedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL resume_idle: busy=%b want 0", busy);
      end
   endtask

`ifdef A2D_FRESH_EN
   task automatic test_fresh_collide;
      int  cyc = 0;
      logic cm = 1'b0;
      pulse_start(3'd5);
      while (cyc < LAT) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == LAT - 1) begin
            rd_chnnl = 3'd5;
            rd_ack   = 1'b1;
         end
      end
      rd_ack = 1'b0;
      cm     = cnv_cmplt;
      n_cmp++;
      if (cm !== 1'b1 || fresh !== 8'hFF) begin
         n_bad++;
         $display("FAIL fresh_collide: cmplt=%b fresh=%h want 1 ff", cm, fresh);
      end
      rd_ack = 1'b1;
      @(posedge clk); #1;
      rd_ack = 1'b0;
      n_cmp++;
      if (fresh !== 8'hDF) begin
         n_bad++;
         $display("FAIL fresh_reack: got %h want df", fresh);
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < 8; i++) adc_mem[i] = 12'h100 * 12'(i) + 12'h001;
      adc_mem[3] = 12'hA5C;
      strt_cnv = 1'b0;
      chnnl    = '0;
      scan_en  = 1'b0;
      rd_chnnl = '0;
`ifdef A2D_FRESH_EN
      rd_ack   = 1'b0;
`endif
      test_reset;
      test_single;
      test_reset_mid_frame;
      test_scan;
      test_scan_stop;
`ifdef A2D_FRESH_EN
      test_fresh_collide;
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
